pkt_framer: RTL
===============

Name: pkt_framer

Overview:
Upstream packet source for the head/data/tail framing state machine. It accepts a packet command (header word plus payload length) and streams the payload from a word source. It emits one framed packet on the valid/head/tail/data bus: a header beat, N payload beats, then a trailer beat. Its valid/head/tail outputs drive the framing FSM's inputs directly.

Parameters:
DATA_W, 16, width of header, payload and trailer words
LEN_W, 8, width of the payload length field (0 to 2^LEN_W-1 payload beats)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  packet command offered
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_len  input  LEN_W  payload beat count N
cmd_hdr  input  DATA_W  header word
pay_valid  input  1  payload word offered
pay_ready  output  1  payload word consumed when pay_valid & pay_ready
pay_data  input  DATA_W  payload word
out_ready  input  1  downstream accepts current beat (tie 1 if no backpressure)
valid  output  1  beat present on head/tail/data
head  output  1  first beat of frame, qualified by valid
tail  output  1  last beat of frame, qualified by valid
data  output  DATA_W  beat data
busy  output  1  state != S_IDLE

Behaviour:
- Reset (async): state S_IDLE. valid, head, tail, data, busy, counter and checksum all 0. cmd_ready=0 while reset is high.
- Outputs valid/head/tail/data are registered. Define load_en = !valid | out_ready. A beat is held stable while valid & !out_ready.
- head and tail never assert on the same beat. Minimum frame is 2 beats (header + trailer).
- S_IDLE: cmd_ready = !reset. On cmd_valid & cmd_ready: latch cmd_len into cnt and cmd_hdr into hdr_q, clear csum, go to S_HEAD. If load_en, load valid=0, head=0, tail=0.
- S_HEAD: on load_en, load valid=1, head=1, tail=0, data=hdr_q. Go to S_DATA if cnt!=0, else S_TAIL.
- S_DATA: pay_ready = load_en (combinational).
  - On pay_valid & pay_ready: load valid=1, head=0, tail=0, data=pay_data; csum ^= pay_data; cnt -= 1. Go to S_TAIL when cnt was 1.
  - On load_en & !pay_valid: load valid=0 (bubble); head and tail stay 0.
- S_TAIL: on load_en, load valid=1, head=0, tail=1, data=trailer word (see Optional Feature). Go to S_IDLE.
- pay_ready=0 in all states except S_DATA. cmd_ready=0 in all states except S_IDLE.
- Latency: command accepted at edge T, header beat valid after T+1 (if load_en).
- Throughput: with out_ready=1 and gapless payload, a frame occupies N+2 consecutive valid cycles. At least 1 non-valid cycle separates back-to-back frames.
- Counter: cnt is LEN_W wide and never decrements below 0. N=2^LEN_W-1 is legal.
- Commands offered while busy are not accepted and are not lost: the source holds them.
- Reset mid-frame: the frame is abandoned and outputs clear immediately. No tail is emitted. The next frame starts cleanly after reset deasserts.

Optional Feature:
PKT_FRAMER_CHECKSUM_EN
- Defined: trailer data = XOR of all N payload words of the frame (0 when N=0). The csum register is present.
- Undefined: trailer data = 0 and the csum register is removed.
- Framing, timing and handshakes are identical in both builds.

Test Plan:
- Normal frame (CHECKSUM_EN, out_ready=1): cmd_hdr=16'h0055, cmd_len=3, payload 16'h1111, 16'h2222, 16'h4444 gapless -> 5 consecutive valid beats: 0055(head=1), 1111, 2222, 4444, 7777(tail=1). Then valid=0. busy low after the tail loads.
- Zero-length frame: cmd_len=0, cmd_hdr=16'h00AA -> 2 beats: 00AA(head), then 0000(tail). pay_ready never asserted.
- Backpressure: hold out_ready=0 for 3 cycles while the header beat is valid -> valid/head/data remain 1/1/00AA unchanged, pay_ready=0. The frame resumes on out_ready=1 with no beat lost.
- Payload bubble: pay_valid low 2 cycles mid-payload -> valid=0 for 2 cycles with head=tail=0. Payload order is preserved and the checksum is correct.
- Busy command: second cmd_valid held during a frame -> cmd_ready=0 until S_IDLE. Then accepted, with exactly 1 idle cycle between the first frame's tail and the second frame's head.
- Reset mid-S_DATA: assert reset asynchronously -> valid/head/tail/data=0 before the next clock edge. After deassert, cmd_ready=1 and a new cmd_len=1 frame produces head, data and tail beats correctly.

Source files
------------

// File: rtl/pkt_framer_if.sv
// pkt_framer_if: bundles the command, payload and framed-output handshakes
// of pkt_framer.
//   Command : cmd_valid, cmd_ready, cmd_len (payload beat count), cmd_hdr
//   Payload : pay_valid, pay_ready, pay_data
//   Output  : out_ready (downstream accept), valid, head, tail, data, busy
// Modports:
//   slave  - the framer's view (it drives ready, beat and busy signals)
//   master - the environment's view (it drives commands, payload, out_ready)
interface pkt_framer_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_hdr;
  logic              pay_valid;
  logic              pay_ready;
  logic [DATA_W-1:0] pay_data;
  logic              out_ready;
  logic              valid;
  logic              head;
  logic              tail;
  logic [DATA_W-1:0] data;
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_len, cmd_hdr, pay_valid, pay_data, out_ready,
    output cmd_ready, pay_ready, valid, head, tail, data, busy
  );

  modport master (
    output cmd_valid, cmd_len, cmd_hdr, pay_valid, pay_data, out_ready,
    input  cmd_ready, pay_ready, valid, head, tail, data, busy
  );
endinterface

// File: rtl/pkt_framer.sv
// pkt_framer: accepts a packet command (header word + payload length N),
// then emits one frame on the valid/head/tail/data bus: a header beat,
// N payload beats pulled from the payload source, and a trailer beat.
// Output beats are registered and held while valid & !out_ready.
//
// Ports:
//   clk   - system clock, all state on the rising edge
//   reset - asynchronous, active-high reset; abandons any frame in flight
//   bus   - pkt_framer_if.slave: command handshake, payload handshake,
//           framed output beat (valid/head/tail/data), out_ready, busy
//
// Build option: define PKT_FRAMER_CHECKSUM_EN to make the trailer word the
// XOR of all payload words of the frame; otherwise the trailer is zero and
// no checksum register exists.
module pkt_framer #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  pkt_framer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] hdr_q, hdr_nxt;
  logic              beat_valid, beat_valid_nxt;
  logic              beat_head, beat_head_nxt;
  logic              beat_tail, beat_tail_nxt;
  logic [DATA_W-1:0] beat_data, beat_data_nxt;
  logic [DATA_W-1:0] trailer;
  logic              load_en;
  logic              cmd_ready;
  logic              pay_ready;

`ifdef PKT_FRAMER_CHECKSUM_EN
  logic [DATA_W-1:0] csum, csum_nxt;

  function automatic logic [DATA_W-1:0] csum_fold(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] word
  );
    return acc ^ word;
  endfunction

  assign trailer = csum;
`else
  assign trailer = '0;
`endif

  // The output register may take a new beat when it is empty or being consumed.
  assign load_en = !beat_valid || bus.out_ready;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hdr_nxt        = hdr_q;
    beat_valid_nxt = beat_valid;
    beat_head_nxt  = beat_head;
    beat_tail_nxt  = beat_tail;
    beat_data_nxt  = beat_data;
    cmd_ready      = 1'b0;
    pay_ready      = 1'b0;
`ifdef PKT_FRAMER_CHECKSUM_EN
    csum_nxt       = csum;
`endif
    case (state)
      S_IDLE: begin
        cmd_ready = !reset;
        if (load_en) begin
          beat_valid_nxt = 1'b0;
          beat_head_nxt  = 1'b0;
          beat_tail_nxt  = 1'b0;
        end
        if (bus.cmd_valid && cmd_ready) begin
          cnt_nxt   = bus.cmd_len;
          hdr_nxt   = bus.cmd_hdr;
          state_nxt = S_HEAD;
`ifdef PKT_FRAMER_CHECKSUM_EN
          csum_nxt  = '0;
`endif
        end
      end
      S_HEAD: begin
        if (load_en) begin
          beat_valid_nxt = 1'b1;
          beat_head_nxt  = 1'b1;
          beat_tail_nxt  = 1'b0;
          beat_data_nxt  = hdr_q;
          state_nxt      = (cnt != '0) ? S_DATA : S_TAIL;
        end
      end
      S_DATA: begin
        pay_ready = load_en;
        if (bus.pay_valid && pay_ready) begin
          beat_valid_nxt = 1'b1;
          beat_head_nxt  = 1'b0;
          beat_tail_nxt  = 1'b0;
          beat_data_nxt  = bus.pay_data;
`ifdef PKT_FRAMER_CHECKSUM_EN
          csum_nxt       = csum_fold(csum, bus.pay_data);
`endif
          // cnt is nonzero on entry to S_DATA; the guard keeps it from wrapping.
          if (cnt != '0) cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nxt = S_TAIL;
        end else if (load_en) begin
          // Payload starved: emit a bubble rather than stall the bus.
          beat_valid_nxt = 1'b0;
          beat_head_nxt  = 1'b0;
          beat_tail_nxt  = 1'b0;
        end
      end
      S_TAIL: begin
        if (load_en) begin
          beat_valid_nxt = 1'b1;
          beat_head_nxt  = 1'b0;
          beat_tail_nxt  = 1'b1;
          beat_data_nxt  = trailer;
          state_nxt      = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hdr_q      <= '0;
      beat_valid <= 1'b0;
      beat_head  <= 1'b0;
      beat_tail  <= 1'b0;
      beat_data  <= '0;
`ifdef PKT_FRAMER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hdr_q      <= hdr_nxt;
      beat_valid <= beat_valid_nxt;
      beat_head  <= beat_head_nxt;
      beat_tail  <= beat_tail_nxt;
      beat_data  <= beat_data_nxt;
`ifdef PKT_FRAMER_CHECKSUM_EN
      csum       <= csum_nxt;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.pay_ready = pay_ready;
  assign bus.valid     = beat_valid;
  assign bus.head      = beat_head;
  assign bus.tail      = beat_tail;
  assign bus.data      = beat_data;
  assign bus.busy      = (state != S_IDLE);

endmodule
